// File: rtl/vhdci_mux_pkg.sv
// Shared types and sync constants for both ends of the VHDCI mux link.
// The FPGA-side initiator imports the same package.
package vhdci_mux_pkg;

  localparam int unsigned WORD_W  = 8;
  localparam int unsigned DATA_W  = 7;
  localparam int unsigned DROP_W  = 8;
  localparam int unsigned MON_BIT = 7;

  localparam logic [WORD_W-1:0] SYNC_HUNT  = 8'h01;
  localparam logic [WORD_W-1:0] SYNC_ALIGN = 8'h81;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ALIGNED = 2'd1,
    LINKED  = 2'd2
  } link_state_e;

  // Word on the wire once linked: toggling monitor bit over 7-bit payload.
  typedef struct packed {
    logic              mon;
    logic [DATA_W-1:0] data;
  } link_word_t;

  function automatic logic is_sync_word(input logic [WORD_W-1:0] w);
    return (w == SYNC_HUNT) || (w == SYNC_ALIGN);
  endfunction

endpackage

// File: rtl/vhdci_mux_mon_check.sv
// Toggle-monitor checker: arms on the first non-0x81 word, then requires
// the monitor bit to alternate every cycle while enabled.
module vhdci_mux_mon_check (
  input  logic clk_mux_div,
  input  logic reset_sync,
  input  logic en_i,
  input  logic rx_bit_i,
  input  logic word_is_sync_i,
  output logic valid_o,
  output logic error_c_o
);

  logic valid_q, valid_d;
  logic expect_q, expect_d;

  assign valid_o   = valid_q;
  assign error_c_o = en_i && valid_q && (rx_bit_i != expect_q);

  always_comb begin
    valid_d  = valid_q;
    expect_d = expect_q;
    if (!en_i) begin
      valid_d = 1'b0;
    end else if (!valid_q) begin
      // Peer may still be repeating its sync pattern; wait for real data.
      if (!word_is_sync_i) begin
        valid_d  = 1'b1;
        expect_d = ~rx_bit_i;
      end
    end else if (error_c_o) begin
      valid_d = 1'b0;
    end else begin
      expect_d = ~rx_bit_i;
    end
  end

  always_ff @(posedge clk_mux_div or posedge reset_sync) begin
    if (reset_sync) begin
      valid_q  <= 1'b0;
      expect_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      expect_q <= expect_d;
    end
  end

endmodule

// File: rtl/vhdci_mux_remote_link.sv
// Far-end framing/sync controller: bitslip word alignment, 0x01/0x81 sync
// handshake, then 7-bit payload with a toggling monitor bit.
module vhdci_mux_remote_link
  import vhdci_mux_pkg::*;
#(
  parameter int unsigned BITSLIP_HOLD  = 3,
  parameter int unsigned MATCH_COUNT   = 4,
  parameter int unsigned ALIGN_TIMEOUT = 1024
) (
  input  logic              clk_mux_div,
  input  logic              reset_sync,
  input  logic [WORD_W-1:0] rx_word,
  output logic [WORD_W-1:0] tx_word,
  output logic              bitslip,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              link_up,
  output logic [DROP_W-1:0] drop_count,
  output logic [1:0]        state_dbg
);

  localparam int unsigned HOLD_W  = $clog2(BITSLIP_HOLD + 1);
  localparam int unsigned MATCH_W = $clog2(MATCH_COUNT + 1);
  localparam int unsigned TOUT_W  = $clog2(ALIGN_TIMEOUT);

  link_state_e state_q, state_d;

  logic [WORD_W-1:0]  rx_q;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [TOUT_W-1:0]  timeout_cnt_q, timeout_cnt_d;
  logic [WORD_W-1:0]  tx_word_q, tx_word_d;
  logic               bitslip_q, bitslip_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               link_up_q, link_up_d;
  logic [DROP_W-1:0]  drop_count_q, drop_count_d;
  logic               mon_tx_q, mon_tx_d;

  logic mon_valid;
  logic mon_err_c;
  logic rx_is_sync_c;
  logic match_done_c;
  logic timeout_done_c;

  assign rx_is_sync_c   = is_sync_word(rx_q);
  assign match_done_c   = (match_cnt_q == MATCH_W'(MATCH_COUNT - 1));
  assign timeout_done_c = (timeout_cnt_q == TOUT_W'(ALIGN_TIMEOUT - 1));

  vhdci_mux_mon_check u_mon_check (
    .clk_mux_div    (clk_mux_div),
    .reset_sync     (reset_sync),
    .en_i           (state_q == LINKED),
    .rx_bit_i       (rx_q[MON_BIT]),
    .word_is_sync_i (rx_q == SYNC_ALIGN),
    .valid_o        (mon_valid),
    .error_c_o      (mon_err_c)
  );

  always_ff @(posedge clk_mux_div or posedge reset_sync) begin
    if (reset_sync) state_q <= HUNT;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT: begin
        if ((hold_cnt_q == '0) && rx_is_sync_c && match_done_c) state_d = ALIGNED;
      end
      ALIGNED: begin
        // A peer 0x81 beats a simultaneous timeout.
        if (rx_q == SYNC_ALIGN)                            state_d = LINKED;
        else if ((rx_q != SYNC_HUNT) || timeout_done_c)    state_d = HUNT;
      end
      LINKED: begin
        if (mon_err_c) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    tx_word_d     = tx_word_q;
    bitslip_d     = 1'b0;
    data_out_d    = data_out_q;
    hold_cnt_d    = hold_cnt_q;
    match_cnt_d   = match_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    mon_tx_d      = mon_tx_q;
    drop_count_d  = drop_count_q;
    data_valid_d  = (state_q == LINKED) && mon_valid;
    link_up_d     = (state_q == LINKED);
    case (state_q)
      HUNT: begin
        tx_word_d = SYNC_HUNT;
        if (hold_cnt_q != '0) begin
          hold_cnt_d  = hold_cnt_q - HOLD_W'(1);
          match_cnt_d = '0;
        end else if (!rx_is_sync_c) begin
          // Hold count guarantees bitslip never fires on back-to-back cycles.
          bitslip_d   = 1'b1;
          hold_cnt_d  = HOLD_W'(BITSLIP_HOLD);
          match_cnt_d = '0;
        end else begin
          match_cnt_d = match_cnt_q + MATCH_W'(1);
        end
      end
      ALIGNED: begin
        tx_word_d     = SYNC_ALIGN;
        timeout_cnt_d = timeout_cnt_q + TOUT_W'(1);
        mon_tx_d      = 1'b0;
      end
      LINKED: begin
        tx_word_d  = link_word_t'{mon: mon_tx_q, data: data_in};
        mon_tx_d   = ~mon_tx_q;
        data_out_d = rx_q[DATA_W-1:0];
        if (mon_err_c && (drop_count_q != '1)) drop_count_d = drop_count_q + DROP_W'(1);
      end
      default: ;
    endcase
    // Every state change starts the per-state counters from zero.
    if (state_d != state_q) begin
      hold_cnt_d    = '0;
      match_cnt_d   = '0;
      timeout_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_mux_div or posedge reset_sync) begin
    if (reset_sync) begin
      rx_q          <= '0;
      hold_cnt_q    <= '0;
      match_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      tx_word_q     <= '0;
      bitslip_q     <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      link_up_q     <= 1'b0;
      drop_count_q  <= '0;
      mon_tx_q      <= 1'b0;
    end else begin
      rx_q          <= rx_word;
      hold_cnt_q    <= hold_cnt_d;
      match_cnt_q   <= match_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      tx_word_q     <= tx_word_d;
      bitslip_q     <= bitslip_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      link_up_q     <= link_up_d;
      drop_count_q  <= drop_count_d;
      mon_tx_q      <= mon_tx_d;
    end
  end

  assign tx_word    = tx_word_q;
  assign bitslip    = bitslip_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign link_up    = link_up_q;
  assign drop_count = drop_count_q;
  assign state_dbg  = state_q;

endmodule
